// File: rtl/codeword_pkg.sv
// Shared encodings and defaults for the codeword detection statistics path.
package codeword_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // "No gap measured" marker at the default result width
  localparam logic [CNT_W_DEF-1:0] GAP_NONE = '1;
endpackage

// File: rtl/codeword_event_counter_if.sv
// Control, detection input and valid/ready result port of the event counter.
interface codeword_event_counter_if import codeword_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
);
  logic             start;
  logic             stop;
  logic [WIN_W-1:0] win_len;
  logic             seq_detect;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W-1:0] res_min_gap;
  logic             res_ovf;

  modport master (
    output start, stop, win_len, seq_detect, res_ready,
    input  busy, res_valid, res_count, res_min_gap, res_ovf
  );

  modport slave (
    input  start, stop, win_len, seq_detect, res_ready,
    output busy, res_valid, res_count, res_min_gap, res_ovf
  );
endinterface

// File: rtl/codeword_event_counter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic         sat_o
);
  logic [W-1:0] value_q, value_d;

  assign sat_o   = &value_q;
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (clr_i)               value_d = '0;
    else if (inc_i && !sat_o) value_d = value_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end
endmodule

// File: rtl/codeword_event_counter.sv
// Counts detection pulses over a programmable window and reports count, minimum spacing and overflow.
module codeword_event_counter import codeword_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  codeword_event_counter_if.slave  bus
);
  localparam logic [CNT_W-1:0] GAP_ALL = '1;

  state_e           st_q;
  logic [WIN_W-1:0] win_len_q, win_cnt_q;
  logic [CNT_W-1:0] min_q, min_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, res_valid_q, res_ovf_q;
  logic [CNT_W-1:0] res_count_q, res_min_gap_q;

  logic             go, run, hit, last;
  logic [CNT_W-1:0] cnt_val, gap_val, cnt_fin, gap_meas;
  logic             cnt_sat, gap_sat;

  assign go   = (st_q == ST_IDLE) && bus.start && (bus.win_len != '0);
  assign run  = (st_q == ST_RUN);
  assign hit  = run && bus.seq_detect;
  assign last = (win_cnt_q == win_len_q - WIN_W'(1));

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(go), .inc_i(hit),
    .value_o(cnt_val), .sat_o(cnt_sat)
  );

  // Gap counter tracks cycles since the last hit; restarts from zero on every hit.
  sat_counter #(.W(CNT_W)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr_i(go || hit), .inc_i(run && !bus.seq_detect),
    .value_o(gap_val), .sat_o(gap_sat)
  );

  always_comb begin
    cnt_fin  = (hit && !cnt_sat) ? cnt_val + CNT_W'(1) : cnt_val;
    gap_meas = gap_sat ? GAP_ALL : gap_val + CNT_W'(1);
    min_d    = min_q;
    // A nonzero count means an earlier hit exists in this window
    if (hit && (cnt_val != '0) && (gap_meas < min_q)) min_d = gap_meas;
    ovf_d = ovf_q | (hit && cnt_sat) | (run && !bus.seq_detect && gap_sat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      win_len_q     <= '0;
      win_cnt_q     <= '0;
      min_q         <= GAP_ALL;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_count_q   <= '0;
      res_min_gap_q <= GAP_ALL;
      res_ovf_q     <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: if (go) begin
          win_len_q <= bus.win_len;
          win_cnt_q <= '0;
          min_q     <= GAP_ALL;
          ovf_q     <= 1'b0;
          busy_q    <= 1'b1;
          st_q      <= ST_RUN;
        end
        ST_RUN: if (bus.stop) begin
          busy_q <= 1'b0;
          st_q   <= ST_IDLE;
        end else begin
          min_q     <= min_d;
          ovf_q     <= ovf_d;
          win_cnt_q <= win_cnt_q + WIN_W'(1);
          if (last) begin
            res_count_q   <= cnt_fin;
            res_min_gap_q <= min_d;
            res_ovf_q     <= ovf_d;
            res_valid_q   <= 1'b1;
            st_q          <= ST_HOLD;
          end
        end
        ST_HOLD: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          st_q        <= ST_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          st_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_count   = res_count_q;
  assign bus.res_min_gap = res_min_gap_q;
  assign bus.res_ovf     = res_ovf_q;
endmodule

// File: tb/tb_codeword_event_counter.sv
// Directed bench: window counting, min gap, saturation, hold/handshake, abort and reset.
module tb_codeword_event_counter;
  import codeword_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  codeword_event_counter_if #(.CNT_W(16), .WIN_W(20)) ifc ();
  codeword_event_counter_if #(.CNT_W(4),  .WIN_W(20)) ifs ();

  codeword_event_counter #(.CNT_W(16), .WIN_W(20)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
  codeword_event_counter #(.CNT_W(4),  .WIN_W(20)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifs));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_win(input int len, input logic [31:0] hits, input int stop_idx);
    ifc.start = 1'b1; ifc.win_len = 20'(len);
    step();
    ifc.start = 1'b0;
    for (int i = 0; i < len; i++) begin
      ifc.seq_detect = hits[i];
      ifc.stop       = (i == stop_idx);
      step();
      if (i == stop_idx) break;
    end
    ifc.seq_detect = 1'b0; ifc.stop = 1'b0;
  endtask

  task automatic handshake();
    ifc.res_ready = 1'b1; step(); ifc.res_ready = 1'b0;
  endtask

  task automatic check_res(input string nm, input logic v, input logic [15:0] c, input logic [15:0] m, input logic o);
    // Not a shared check helper in spirit: scenario-local result snapshot compare
    n_cmp++; if (ifc.res_valid !== v) begin n_err++; $display("FAIL %s_valid: got %b want %b", nm, ifc.res_valid, v); end
    n_cmp++; if (ifc.res_count !== c) begin n_err++; $display("FAIL %s_count: got %0d want %0d", nm, ifc.res_count, c); end
    n_cmp++; if (ifc.res_min_gap !== m) begin n_err++; $display("FAIL %s_min_gap: got %h want %h", nm, ifc.res_min_gap, m); end
    n_cmp++; if (ifc.res_ovf !== o) begin n_err++; $display("FAIL %s_ovf: got %b want %b", nm, ifc.res_ovf, o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.start = 0; ifc.stop = 0; ifc.win_len = '0; ifc.seq_detect = 0; ifc.res_ready = 0;
    ifs.start = 0; ifs.stop = 0; ifs.win_len = '0; ifs.seq_detect = 0; ifs.res_ready = 0;
    step(); step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    check_res("reset", 1'b0, 16'd0, GAP_NONE, 1'b0);
    n_cmp++; if (ifs.res_min_gap !== 4'hF) begin n_err++; $display("FAIL reset4_min_gap: got %h want f", ifs.res_min_gap); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_win(10, 32'b00_0110_0100, -1);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", ifc.busy); end
    check_res("basic", 1'b1, 16'd3, 16'd1, 1'b0);
    handshake();
  endtask

  task automatic test_nohit();
    run_win(5, 32'b0, -1);
    check_res("nohit", 1'b1, 16'd0, GAP_NONE, 1'b0);
    handshake();
    run_win(5, 32'b1_0000, -1);
    check_res("onehit", 1'b1, 16'd1, GAP_NONE, 1'b0);
    handshake();
  endtask

  task automatic test_saturation();
    ifs.start = 1'b1; ifs.win_len = 20'd20;
    step();
    ifs.start = 1'b0; ifs.seq_detect = 1'b1;
    for (int i = 0; i < 20; i++) step();
    ifs.seq_detect = 1'b0;
    n_cmp++; if (ifs.res_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", ifs.res_valid); end
    n_cmp++; if (ifs.res_count !== 4'd15) begin n_err++; $display("FAIL sat_count: got %0d want 15", ifs.res_count); end
    n_cmp++; if (ifs.res_ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", ifs.res_ovf); end
    n_cmp++; if (ifs.res_min_gap !== 4'd1) begin n_err++; $display("FAIL sat_min_gap: got %0d want 1", ifs.res_min_gap); end
    ifs.res_ready = 1'b1; step(); ifs.res_ready = 1'b0;
    n_cmp++; if (ifs.busy !== 1'b0) begin n_err++; $display("FAIL sat_release: busy got %b want 0", ifs.busy); end
  endtask

  task automatic test_hold();
    run_win(6, 32'b10_1001, -1);
    check_res("hold_entry", 1'b1, 16'd3, 16'd2, 1'b0);
    ifc.start = 1'b1; ifc.win_len = 20'd4; ifc.seq_detect = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++; if (ifc.res_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, ifc.res_valid); end
      n_cmp++; if (ifc.res_count !== 16'd3 || ifc.res_min_gap !== 16'd2) begin
        n_err++; $display("FAIL hold_stable[%0d]: got %0d/%0d want 3/2", i, ifc.res_count, ifc.res_min_gap); end
    end
    handshake();
    ifc.seq_detect = 1'b0;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL hold_release_busy: got %b want 0", ifc.busy); end
    check_res("hold_release", 1'b0, 16'd3, 16'd2, 1'b0);
    ifc.start = 1'b0;
    step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL hold_start_ignored: busy got %b want 0", ifc.busy); end
  endtask

  task automatic test_stop();
    run_win(10, 32'b11, 3);
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", ifc.busy); end
    check_res("stop", 1'b0, 16'd3, 16'd2, 1'b0);
    step();
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_err++; $display("FAIL stop_valid_later: got %b want 0", ifc.res_valid); end
    ifc.start = 1'b1; ifc.win_len = 20'd0;
    step();
    ifc.start = 1'b0;
    step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL zero_len_busy: got %b want 0", ifc.busy); end
    // stop on the final cycle still aborts
    run_win(4, 32'b1111, 3);
    n_cmp++; if (ifc.res_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      n_err++; $display("FAIL stop_last: valid %b busy %b want 0 0", ifc.res_valid, ifc.busy); end
  endtask

  task automatic test_reset_mid();
    ifc.start = 1'b1; ifc.win_len = 20'd10;
    step();
    ifc.start = 1'b0; ifc.seq_detect = 1'b1;
    step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1; ifc.seq_detect = 1'b0;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b want 0", ifc.busy); end
    check_res("rst_run", 1'b0, 16'd0, GAP_NONE, 1'b0);
    run_win(4, 32'b10, -1);
    check_res("pre_rst_hold", 1'b1, 16'd1, GAP_NONE, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_hold_busy: got %b want 0", ifc.busy); end
    check_res("rst_hold", 1'b0, 16'd0, GAP_NONE, 1'b0);
    run_win(3, 32'b011, -1);
    check_res("after_rst", 1'b1, 16'd2, 16'd1, 1'b0);
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nohit();
    test_saturation();
    test_hold();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
